adex_isi_logger: RTL and testbench

Downstream consumer of the AdEx neuron core. Measures inter-spike intervals (ISIs) in neuron-update ticks, buffers them in a small FIFO and serves them to the host as 4-bit nibbles over a strobe handshake. This keeps spike timing intact when the 6-bit membrane/adaptation monitor pins are too slow to sample.

---
 rtl/adex_isi_logger.sv | 148 ++++++++++++++
 tb/tb_adex_isi_logger.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adex_isi_logger.sv
// Inter-spike interval logger: counts neuron-update ticks between spikes, buffers ISIs in a FIFO
// and serves them MSB-nibble first on a strobe handshake. Optional burst counter: ADEX_ISI_BURST_DETECT_EN.
module adex_isi_logger #(
  parameter int               ISI_W     = 12,
  parameter int               DEPTH     = 8,
  parameter logic [ISI_W-1:0] BURST_THR = 12'd8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     tick_in,
  input  logic                     spike_in,
  input  logic                     clear,
  input  logic                     rd_req,
  output logic [3:0]               rd_nibble,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               burst_cnt
);

  localparam int NIBS  = ISI_W / 4;
  localparam int NIB_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ISI_W-1:0] ISI_MAX  = '1;
  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIBS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {S_ARMED, S_COUNT} state_t;

  state_t           state, state_nxt;
  logic [ISI_W-1:0] isi_cnt, isi_nxt, isi_inc, push_val;
  logic             push, push_ok, drop, rd_fire, pop;

  logic [ISI_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [NIB_W-1:0] nib_idx, nib_sel;
  logic [ISI_W-1:0] head_sh;

  assign isi_inc = (isi_cnt == ISI_MAX) ? ISI_MAX : isi_cnt + ISI_W'(1);

  always_comb begin
    state_nxt = state;
    isi_nxt   = isi_cnt;
    push      = 1'b0;
    push_val  = isi_cnt;
    if (!enable) begin
      state_nxt = S_ARMED;
      isi_nxt   = '0;
    end else begin
      case (state)
        S_ARMED: begin
          isi_nxt = '0;
          if (spike_in) state_nxt = S_COUNT;
        end
        S_COUNT: begin
          if (tick_in) isi_nxt = isi_inc;
          // A tick coincident with the spike belongs to the interval being closed.
          if (spike_in) begin
            push     = 1'b1;
            push_val = tick_in ? isi_inc : isi_cnt;
            isi_nxt  = '0;
          end
        end
        default: begin
          state_nxt = S_ARMED;
          isi_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state   <= S_ARMED;
      isi_cnt <= '0;
    end else begin
      state   <= state_nxt;
      isi_cnt <= isi_nxt;
    end
  end

  assign rd_fire = rd_req && (count != '0) && !clear;
  assign pop     = rd_fire && (nib_idx == NIB_LAST);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && !clear && ((count != FULL_CNT) || pop);
  assign drop    = push && !clear && !push_ok;

  assign nib_sel = NIB_LAST - nib_idx;
  assign head_sh = mem[rd_ptr] >> {nib_sel, 2'b00};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      nib_idx   <= '0;
      overflow  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_nibble <= 4'h0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      nib_idx  <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        rd_nibble <= head_sh[3:0];
        nib_idx   <= pop ? '0 : nib_idx + NIB_W'(1);
      end
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push_ok) count <= count - CNT_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  assign fifo_count = count;

`ifdef ADEX_ISI_BURST_DETECT_EN
  logic [7:0] burst_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      burst_q <= 8'd0;
    end else if (push_ok && (push_val < BURST_THR) && (burst_q != 8'hFF)) begin
      burst_q <= burst_q + 8'd1;
    end
  end

  assign burst_cnt = burst_q;
`else
  logic unused_burst_thr;
  assign unused_burst_thr = ^BURST_THR;
  assign burst_cnt        = 8'd0;
`endif

endmodule

// File: tb/tb_adex_isi_logger.sv
// Directed self-checking bench for adex_isi_logger (default parameters).
module tb_adex_isi_logger;

  logic       clk = 1'b0;
  logic       reset = 1'b0, enable = 1'b0, tick_in = 1'b0, spike_in = 1'b0;
  logic       clear = 1'b0, rd_req = 1'b0;
  logic [3:0] rd_nibble;
  logic       rd_valid;
  logic [3:0] fifo_count;
  logic       overflow;
  logic [7:0] burst_cnt;

  int checks = 0;
  int failures = 0;

  adex_isi_logger dut (
    .clk(clk), .reset(reset), .enable(enable), .tick_in(tick_in),
    .spike_in(spike_in), .clear(clear), .rd_req(rd_req),
    .rd_nibble(rd_nibble), .rd_valid(rd_valid), .fifo_count(fifo_count),
    .overflow(overflow), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic spike();
    spike_in = 1'b1;
    step();
    spike_in = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      step();
    end
    tick_in = 1'b0;
  endtask

  task automatic read_nib(output logic [3:0] nib, output logic vld);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    nib = rd_nibble;
    vld = rd_valid;
  endtask

  task automatic read_entry(output logic [11:0] val, output logic all_vld);
    logic [3:0] n;
    logic       v;
    all_vld = 1'b1;
    val = '0;
    for (int i = 0; i < 3; i++) begin
      read_nib(n, v);
      val = {val[7:0], n};
      all_vld = all_vld & v;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rd_nibble !== 4'h0) begin failures++; $display("FAIL reset_nibble got=%h exp=0", rd_nibble); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (burst_cnt !== 8'd0) begin failures++; $display("FAIL reset_burst got=%0d exp=0", burst_cnt); end
  endtask

  task automatic test_first_spike();
    logic [3:0] n;
    logic       v;
    logic [3:0] exp_n [3] = '{4'h0, 4'h0, 4'h5};
    enable = 1'b1;
    spike();
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL first_arm_count got=%0d exp=0", fifo_count); end
    ticks(5);
    spike();
    checks++; if (fifo_count !== 4'd1) begin failures++; $display("FAIL first_push_count got=%0d exp=1", fifo_count); end
    for (int i = 0; i < 3; i++) begin
      read_nib(n, v);
      checks++; if (n !== exp_n[i] || v !== 1'b1) begin failures++; $display("FAIL first_nib%0d got=%h/%b exp=%h/1", i, n, v, exp_n[i]); end
    end
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL first_drain_count got=%0d exp=0", fifo_count); end
    step();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL first_valid_pulse got=%b exp=0", rd_valid); end
  endtask

  task automatic test_simultaneous();
    logic [11:0] val;
    logic        ok;
    ticks(3);
    tick_in = 1'b1;
    spike_in = 1'b1;
    step();
    tick_in = 1'b0;
    spike_in = 1'b0;
    read_entry(val, ok);
    checks++; if (val !== 12'h004 || !ok) begin failures++; $display("FAIL simul_isi got=%h/%b exp=004/1", val, ok); end
    ticks(5000);
    spike();
    read_entry(val, ok);
    checks++; if (val !== 12'hFFF || !ok) begin failures++; $display("FAIL saturate_isi got=%h/%b exp=fff/1", val, ok); end
  endtask

  task automatic test_overflow();
    logic [11:0] val;
    logic        ok;
    logic [3:0]  n;
    logic        v;
    for (int i = 1; i <= 9; i++) begin
      ticks(i);
      spike();
    end
    checks++; if (fifo_count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", fifo_count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    ticks(10);
    read_nib(n, v);
    read_nib(n, v);
    rd_req = 1'b1;
    spike_in = 1'b1;
    step();
    rd_req = 1'b0;
    spike_in = 1'b0;
    checks++; if (rd_nibble !== 4'h1 || rd_valid !== 1'b1) begin failures++; $display("FAIL ovf_pop_nib got=%h/%b exp=1/1", rd_nibble, rd_valid); end
    checks++; if (fifo_count !== 4'd8) begin failures++; $display("FAIL ovf_pop_push_count got=%0d exp=8", fifo_count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag_kept got=%b exp=1", overflow); end
    for (int i = 2; i <= 8; i++) begin
      read_entry(val, ok);
      checks++; if (val !== 12'(i) || !ok) begin failures++; $display("FAIL ovf_order%0d got=%h/%b exp=%h/1", i, val, ok, 12'(i)); end
    end
    read_entry(val, ok);
    checks++; if (val !== 12'h00A || !ok) begin failures++; $display("FAIL ovf_concurrent_push got=%h/%b exp=00a/1", val, ok); end
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL ovf_drain_count got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_empty_wrap();
    logic [3:0]  n;
    logic        v;
    logic [11:0] val;
    logic        ok;
    read_nib(n, v);
    checks++; if (v !== 1'b0 || n !== 4'hA) begin failures++; $display("FAIL empty_read got=%h/%b exp=a/0", n, v); end
    for (int i = 0; i < 20; i++) begin
      ticks(3 * i + 1);
      spike();
      read_entry(val, ok);
      checks++; if (val !== 12'(3 * i + 1) || !ok) begin failures++; $display("FAIL wrap%0d got=%h/%b exp=%h/1", i, val, ok, 12'(3 * i + 1)); end
    end
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL wrap_count got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_clear_enable();
    logic [3:0]  n;
    logic        v;
    logic [11:0] val;
    logic        ok;
    for (int i = 0; i < 9; i++) begin
      ticks(1);
      spike();
    end
    read_nib(n, v);
    clear = 1'b1;
    spike_in = 1'b1;
    step();
    clear = 1'b0;
    spike_in = 1'b0;
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL clear_count got=%0d exp=0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL clear_overflow got=%b exp=0", overflow); end
    spike();
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL clear_rearm got=%0d exp=0", fifo_count); end
    ticks(2);
    spike();
    read_entry(val, ok);
    checks++; if (val !== 12'h002 || !ok) begin failures++; $display("FAIL clear_next_isi got=%h/%b exp=002/1", val, ok); end
    ticks(3);
    enable = 1'b0;
    step();
    enable = 1'b1;
    ticks(2);
    spike();
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL enable_rearm got=%0d exp=0", fifo_count); end
    ticks(4);
    spike();
    read_entry(val, ok);
    checks++; if (val !== 12'h004 || !ok) begin failures++; $display("FAIL enable_next_isi got=%h/%b exp=004/1", val, ok); end
  endtask

  task automatic test_burst();
    logic [11:0] val;
    logic        ok;
    int          isi [4] = '{3, 7, 8, 20};
    logic [7:0]  exp_burst;
`ifdef ADEX_ISI_BURST_DETECT_EN
    exp_burst = 8'd2;
`else
    exp_burst = 8'd0;
`endif
    clear = 1'b1;
    step();
    clear = 1'b0;
    spike();
    for (int i = 0; i < 4; i++) begin
      ticks(isi[i]);
      spike();
    end
    checks++; if (burst_cnt !== exp_burst) begin failures++; $display("FAIL burst_cnt got=%0d exp=%0d", burst_cnt, exp_burst); end
    for (int i = 0; i < 4; i++) begin
      read_entry(val, ok);
      checks++; if (val !== 12'(isi[i]) || !ok) begin failures++; $display("FAIL burst_isi%0d got=%h/%b exp=%h/1", i, val, ok, 12'(isi[i])); end
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic [3:0] n;
    logic       v;
    ticks(6);
    spike();
    read_nib(n, v);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (fifo_count !== 4'd0 || rd_valid !== 1'b0 || rd_nibble !== 4'h0) begin
      failures++; $display("FAIL midreset got=%0d/%b/%h exp=0/0/0", fifo_count, rd_valid, rd_nibble);
    end
    spike();
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL midreset_rearm got=%0d exp=0", fifo_count); end
  endtask

  initial begin
    test_reset();
    test_first_spike();
    test_simultaneous();
    test_overflow();
    test_empty_wrap();
    test_clear_enable();
    test_burst();
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
